ul_div_seq: RTL and testbench
=============================

# ul_div_seq

Sequential unsigned integer divider for the uplink datapath. It returns both quotient and remainder, where the stateless combinational mod stages return only a remainder. It accepts a dividend/divisor pair over a valid/ready handshake and retires two dividend bits per clock through one restoring 2-bit stage. Results go out on a valid/ready output port. It serves the uplink index arithmetic (rate-matching offsets, Zc/Ncb reductions) wherever the quotient is also needed.

## Interface
Parameters:
- DIVIDEND_WIDTH, 16: dividend and quotient width. Must be even and ≥ 2.
- DIVISOR_WIDTH, 8: divisor and remainder width.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_vld  input  1  input pair valid.
- in_rdy  output  1  block can accept a pair.
- in_dividend  input  DIVIDEND_WIDTH  unsigned dividend.
- in_divider  input  DIVISOR_WIDTH  unsigned divisor.
- out_vld  output  1  result valid.
- out_rdy  input  1  downstream accepts the result.
- out_quotient  output  DIVIDEND_WIDTH  floor(dividend/divider).
- out_remainder  output  DIVISOR_WIDTH  dividend mod divider.
- out_dz  output  1  divide-by-zero flag, qualified by out_vld.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - in_rdy=1.
  - On in_vld&in_rdy: latch dividend into a shift register and divider into a hold register.
  - Clear the partial remainder to 0 and the iteration counter to 0. Go to RUN.
- RUN:
  - Each cycle, feed the partial remainder and the top 2 bits of the dividend shift register into the stage.
  - Per bit: shift the bit into the partial remainder, then subtract divider with one guard bit.
  - Borrow → keep the shifted value; quotient bit 0.
  - No borrow → take the difference; quotient bit 1.
  - Shift the dividend register left by 2. Shift the 2 quotient bits into the LSBs of the quotient register.
  - Invariant: partial remainder < divider at every stage input. Internal subtract width is DIVISOR_WIDTH+2.
  - After DIVIDEND_WIDTH/2 iterations, go to DONE. The counter is $clog2(DIVIDEND_WIDTH/2)+1 bits.
- DONE:
  - out_vld=1. The quotient, remainder and dz registers hold stable.
  - On out_vld&out_rdy: go to IDLE.
- in_rdy is 1 only in IDLE. There is no same-cycle pass-through from DONE to a new accept.
- in_* are ignored outside IDLE.
- Results are mathematically exact for divider≠0.
- Reset values:
  - in_rdy=1 (the reset state is IDLE).
  - out_vld=0, out_quotient=0, out_remainder=0, out_dz=0.
- rst in any state, including mid-RUN or DONE with out_rdy=0: the next cycle is IDLE with all outputs at reset values. The in-flight operation is discarded.

## Timing
- Accept edge E. RUN occupies the cycles after edges E..E+N/2-1, with N=DIVIDEND_WIDTH.
- out_vld rises after edge E+N/2. Latency is N/2 cycles (8 at the default).
- Minimum issue interval: N/2+2 cycles (accept, N/2 RUN cycles, one DONE handshake cycle).
- Backpressure: out_rdy=0 holds DONE indefinitely with outputs stable.
- All outputs are registered. There are no combinational paths from in_* or out_rdy to any output except through the FSM state.

## Configuration
- UL_DIV_ZERO_CHK_EN defined:
  - divider==0 at accept goes straight to DONE. out_vld rises after edge E+1.
  - Results: out_quotient = all ones, out_remainder=0, out_dz=1.
- UL_DIV_ZERO_CHK_EN undefined:
  - No check. divider==0 runs the full N/2 iterations.
  - Results: out_quotient = all ones, out_remainder = in_dividend[DIVISOR_WIDTH-1:0] (zero-extended if DIVIDEND_WIDTH<DIVISOR_WIDTH).
  - out_dz is tied to 0.

## Structure
- Shared package ul_div_pkg holds:
  - the FSM state enum ul_div_state_t (IDLE/RUN/DONE);
  - the localparam helper for iteration count.
- One sub-module: ul_div_2stage. It is combinational, with two chained restoring steps.
  - Inputs: init, 2 dividend bits, divider.
  - Outputs: remainder and 2 quotient bits.
  - It is instantiated once in ul_div_seq.

## Test plan
- 1000/7 with out_rdy=1: out_vld exactly 8 cycles after accept; q=142, r=6, dz=0; in_rdy returns 1 the cycle after the output handshake.
- Back-to-back 65535/255 then 5/9: q=257,r=0 then q=0,r=5; in_rdy low throughout RUN and DONE.
- 0x00FF/1 with out_rdy held 0 for 5 cycles after out_vld: outputs stay q=255,r=0 every cycle; in_vld pulses meanwhile are ignored.
- 0x1234/0:
  - With UL_DIV_ZERO_CHK_EN: out_vld 1 cycle after accept; q=0xFFFF, r=0, dz=1.
  - Without UL_DIV_ZERO_CHK_EN: 8-cycle latency; q=0xFFFF, r=0x34, dz=0.
- rst asserted in the 4th RUN cycle of 40000/3: next cycle in_rdy=1 and out_vld=0. A following 9/4 yields q=2, r=1.
- Random sweep of 10k pairs with divider≠0 against a reference model: exact q/r match, constant 8-cycle latency.

Source files
------------

// File: rtl/ul_div_pkg.sv
// ul_div_pkg: shared FSM state type and iteration helper for the sequential divider.
//   ul_div_state_t : IDLE / RUN / DONE
//   ul_div_iters() : number of 2-bit iterations for a given dividend width
package ul_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ul_div_state_t;

    function automatic int ul_div_iters(input int dividend_width);
        return dividend_width / 2;
    endfunction

endpackage

// File: rtl/ul_div_if.sv
// ul_div_if: valid/ready input and output ports of the sequential divider.
//   in_vld/in_rdy/in_dividend/in_divider    : operand handshake
//   out_vld/out_rdy/out_quotient/out_remainder/out_dz : result handshake
//   master : producer of operands / consumer of results
//   slave  : the divider
interface ul_div_if #(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8
);
    logic                      in_vld;
    logic                      in_rdy;
    logic [DIVIDEND_WIDTH-1:0] in_dividend;
    logic [DIVISOR_WIDTH-1:0]  in_divider;
    logic                      out_vld;
    logic                      out_rdy;
    logic [DIVIDEND_WIDTH-1:0] out_quotient;
    logic [DIVISOR_WIDTH-1:0]  out_remainder;
    logic                      out_dz;

    modport master (
        output in_vld, in_dividend, in_divider, out_rdy,
        input  in_rdy, out_vld, out_quotient, out_remainder, out_dz
    );

    modport slave (
        input  in_vld, in_dividend, in_divider, out_rdy,
        output in_rdy, out_vld, out_quotient, out_remainder, out_dz
    );
endinterface

// File: rtl/ul_div_2stage.sv
// ul_div_2stage: two chained restoring division steps (combinational).
//   i_init    : partial remainder in (must be < i_divider)
//   i_bits    : next two dividend bits, MSB first
//   i_divider : divisor
//   o_rem     : partial remainder out
//   o_q       : two quotient bits, MSB first
module ul_div_2stage #(
    parameter int DIVISOR_WIDTH = 8
) (
    input  logic [DIVISOR_WIDTH-1:0] i_init,
    input  logic [1:0]               i_bits,
    input  logic [DIVISOR_WIDTH-1:0] i_divider,
    output logic [DIVISOR_WIDTH-1:0] o_rem,
    output logic [1:0]               o_q
);
    localparam int DW = DIVISOR_WIDTH;

    logic [DW:0]   w_sh1, w_sh2;
    logic [DW+1:0] w_d1, w_d2;
    logic [DW-1:0] w_r1;

    // The extra top bit of each difference is the borrow of the guarded subtract.
    assign w_sh1  = {i_init, i_bits[1]};
    assign w_d1   = {1'b0, w_sh1} - {2'b00, i_divider};
    assign o_q[1] = ~w_d1[DW+1];
    assign w_r1   = o_q[1] ? w_d1[DW-1:0] : w_sh1[DW-1:0];

    assign w_sh2  = {w_r1, i_bits[0]};
    assign w_d2   = {1'b0, w_sh2} - {2'b00, i_divider};
    assign o_q[0] = ~w_d2[DW+1];
    assign o_rem  = o_q[0] ? w_d2[DW-1:0] : w_sh2[DW-1:0];
endmodule

// File: rtl/ul_div_seq.sv
// ul_div_seq: sequential unsigned divider, two quotient bits per clock.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : ul_div_if.slave (operand and result valid/ready ports)
// Optional macro UL_DIV_ZERO_CHK_EN: a zero divisor finishes after one RUN
// cycle with quotient all ones, remainder 0 and out_dz set; otherwise a zero
// divisor runs the full iteration count and out_dz stays 0.
module ul_div_seq
    import ul_div_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = 16,
    parameter int DIVISOR_WIDTH  = 8
) (
    input logic   clk,
    input logic   rst,
    ul_div_if.slave bus
);
    localparam int ITER = ul_div_iters(DIVIDEND_WIDTH);
    localparam int CW   = $clog2(ITER) + 1;

    ul_div_state_t             r_state, w_next;
    logic [DIVIDEND_WIDTH-1:0] r_dvd, r_quo;
    logic [DIVISOR_WIDTH-1:0]  r_div, r_rem, w_rem;
    logic [1:0]                w_q;
    logic [CW-1:0]             r_cnt;
    logic                      w_acc, w_last, w_zero;

    assign w_acc  = r_state == IDLE && bus.in_vld;
    assign w_last = r_cnt == CW'(ITER - 1);
`ifdef UL_DIV_ZERO_CHK_EN
    assign w_zero = r_div == '0;
`else
    assign w_zero = 1'b0;
`endif

    ul_div_2stage #(.DIVISOR_WIDTH(DIVISOR_WIDTH)) u_stage (
        .i_init    (r_rem),
        .i_bits    (r_dvd[DIVIDEND_WIDTH-1 -: 2]),
        .i_divider (r_div),
        .o_rem     (w_rem),
        .o_q       (w_q)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = bus.in_vld ? RUN : IDLE;
            RUN:     w_next = (w_last || w_zero) ? DONE : RUN;
            DONE:    w_next = bus.out_rdy ? IDLE : DONE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_rdy  = r_state == IDLE;
        bus.out_vld = r_state == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dvd <= '0;
            r_div <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (w_acc) begin
            r_dvd <= bus.in_dividend;
            r_div <= bus.in_divider;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
        end else if (r_state == RUN) begin
            r_dvd <= r_dvd << 2;
            r_rem <= w_zero ? '0 : w_rem;
            r_quo <= w_zero ? '1 : DIVIDEND_WIDTH'({r_quo, w_q});
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef UL_DIV_ZERO_CHK_EN
    logic r_dz;
    always_ff @(posedge clk) begin
        if (rst || w_acc)                  r_dz <= 1'b0;
        else if (r_state == RUN && w_zero) r_dz <= 1'b1;
    end
    assign bus.out_dz = r_dz;
`else
    assign bus.out_dz = 1'b0;
`endif

    assign bus.out_quotient  = r_quo;
    assign bus.out_remainder = r_rem;
endmodule

// File: tb/tb_ul_div_seq.sv
// tb_ul_div_seq: directed self-checking bench for ul_div_seq.
module tb_ul_div_seq;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_bad;

    ul_div_if #(.DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8)) bus ();

    ul_div_seq #(.DIVIDEND_WIDTH(16), .DIVISOR_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
    } vec_t;

    vec_t vecs [8] = '{
        '{16'd100,   8'd10,  16'd10,    8'd0},
        '{16'd65535, 8'd1,   16'd65535, 8'd0},
        '{16'd255,   8'd16,  16'd15,    8'd15},
        '{16'd50000, 8'd200, 16'd250,   8'd0},
        '{16'd12345, 8'd97,  16'd127,   8'd26},
        '{16'd1,     8'd255, 16'd0,     8'd1},
        '{16'd32768, 8'd128, 16'd256,   8'd0},
        '{16'd60001, 8'd254, 16'd236,   8'd57}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input string tag, input logic [15:0] a, input logic [7:0] b);
        check({tag, ".in_rdy"}, bus.in_rdy, 1);
        bus.in_vld      = 1'b1;
        bus.in_dividend = a;
        bus.in_divider  = b;
        tick();
        bus.in_vld = 1'b0;
    endtask

    task automatic wait_vld(output int lat, output bit rdy_hi);
        lat    = 0;
        rdy_hi = 1'b0;
        while (!bus.out_vld && lat < 40) begin
            if (bus.in_rdy) rdy_hi = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic div_op(input string tag, input logic [15:0] a, input logic [7:0] b,
                          input logic [15:0] eq, input logic [7:0] er, input logic edz,
                          input int elat);
        int lat;
        bit rh;
        start(tag, a, b);
        wait_vld(lat, rh);
        check({tag, ".lat"}, lat, elat);
        check({tag, ".rdy_low"}, rh, 0);
        check({tag, ".rdy_done"}, bus.in_rdy, 0);
        check({tag, ".q"}, bus.out_quotient, eq);
        check({tag, ".r"}, bus.out_remainder, er);
        check({tag, ".dz"}, bus.out_dz, edz);
        bus.out_rdy = 1'b1;
        tick();
        check({tag, ".idle_rdy"}, bus.in_rdy, 1);
        check({tag, ".idle_vld"}, bus.out_vld, 0);
    endtask

    initial begin
        int lat;
        bit rh;
        logic [15:0] ra;
        logic [7:0]  rb;
        n_chk           = 0;
        n_bad           = 0;
        rst             = 1'b1;
        bus.in_vld      = 1'b0;
        bus.in_dividend = '0;
        bus.in_divider  = '0;
        bus.out_rdy     = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst.in_rdy", bus.in_rdy, 1);
        check("rst.out_vld", bus.out_vld, 0);
        check("rst.q", bus.out_quotient, 0);
        check("rst.r", bus.out_remainder, 0);
        check("rst.dz", bus.out_dz, 0);

        div_op("t1000_7", 16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 8);
        div_op("b2b_a", 16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 8);
        div_op("b2b_b", 16'd5, 8'd9, 16'd0, 8'd5, 1'b0, 8);

        bus.out_rdy = 1'b0;
        start("bp", 16'h00FF, 8'd1);
        wait_vld(lat, rh);
        check("bp.lat", lat, 8);
        for (int i = 0; i < 5; i++) begin
            check("bp.vld", bus.out_vld, 1);
            check("bp.q", bus.out_quotient, 16'd255);
            check("bp.r", bus.out_remainder, 0);
            check("bp.in_rdy", bus.in_rdy, 0);
            bus.in_vld      = 1'b1;
            bus.in_dividend = 16'(i * 3 + 7);
            bus.in_divider  = 8'd2;
            tick();
        end
        bus.in_vld = 1'b0;
        check("bp.q_end", bus.out_quotient, 16'd255);
        bus.out_rdy = 1'b1;
        tick();
        check("bp.idle_rdy", bus.in_rdy, 1);
        check("bp.idle_vld", bus.out_vld, 0);
        tick();
        check("bp.no_accept", bus.in_rdy, 1);

`ifdef UL_DIV_ZERO_CHK_EN
        div_op("dz", 16'h1234, 8'd0, 16'hFFFF, 8'd0, 1'b1, 1);
`else
        div_op("dz", 16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b0, 8);
`endif

        start("abort", 16'd40000, 8'd3);
        repeat (3) tick();
        check("abort.running", bus.in_rdy, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort.in_rdy", bus.in_rdy, 1);
        check("abort.out_vld", bus.out_vld, 0);
        check("abort.q", bus.out_quotient, 0);
        check("abort.r", bus.out_remainder, 0);
        div_op("after_abort", 16'd9, 8'd4, 16'd2, 8'd1, 1'b0, 8);

        foreach (vecs[i])
            div_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 1'b0, 8);

        for (int i = 0; i < 200; i++) begin
            ra = 16'($urandom);
            rb = 8'($urandom_range(1, 255));
            div_op($sformatf("rnd%0d", i), ra, rb, ra / 16'(rb), 8'(ra % 16'(rb)), 1'b0, 8);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
